// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter sharing one physical-memory port
// between the I-cache (read only) and the D-cache (read/write-back).
// The winning command is registered and held until memory responds.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | no transaction in flight, requests sampled every edge
// BUSY_I | I-cache line fill outstanding, waiting for pmem_resp
// BUSY_D | D-cache fill or write-back outstanding, waiting for pmem_resp
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic                  i_pmem_resp,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic                  d_pmem_resp,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_d_q, last_d_d;   // 1: D won most recently
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    i_req;
    logic                    d_req;
    logic                    grant_i;
    logic                    grant_d;

    assign i_req   = i_pmem_read;
    assign d_req   = d_pmem_read | d_pmem_write;
    // On a tie the requester that did not win last time goes first.
    assign grant_i = i_req & (~d_req | last_d_q);
    assign grant_d = d_req & (~i_req | ~last_d_q);

    // State, round-robin pointer and the registered memory command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            read_q   <= read_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Grant selection in IDLE, command hold and release while busy.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        read_d   = read_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                    read_d   = 1'b1;
                    write_d  = 1'b0;
                    addr_d   = i_pmem_address;
                end else if (grant_d) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                    // Read and write together is illegal; the write wins.
                    read_d   = d_pmem_read & ~d_pmem_write;
                    write_d  = d_pmem_write;
                    addr_d   = d_pmem_address;
                    if (d_pmem_write) begin
                        wdata_d = d_pmem_wdata;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = (state_q == BUSY_I) & pmem_resp;
    assign d_pmem_resp  = (state_q == BUSY_D) & pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-requester arbiter that shares one physical-memory port between the LC-3b I-cache and D-cache. It sits between the two caches' `pmem_*` interfaces and the single memory (main memory or L2). Each winning request's address, command and write line are registered and held until memory responds. The response and read line are then steered back to the winner. Round-robin priority prevents either cache from starving the other.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word)
- LINE_WIDTH, 128, cache-line width (lc3b_cacheline)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- i_pmem_read  in  1  I-cache line-fill request
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_resp  out  1  I-cache transaction complete
- i_pmem_rdata  out  LINE_WIDTH  line returned to I-cache
- d_pmem_read  in  1  D-cache line-fill request
- d_pmem_write  in  1  D-cache write-back request
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache write-back line
- d_pmem_resp  out  1  D-cache transaction complete
- d_pmem_rdata  out  LINE_WIDTH  line returned to D-cache
- pmem_read  out  1  memory read command (registered)
- pmem_write  out  1  memory write command (registered)
- pmem_address  out  ADDR_WIDTH  memory address (registered)
- pmem_wdata  out  LINE_WIDTH  memory write line (registered)
- pmem_resp  in  1  memory transaction complete
- pmem_rdata  in  LINE_WIDTH  memory read line

## Operation
- States: IDLE, BUSY_I, BUSY_D. Register `last` (I or D) records the most recent winner.
- Request definitions:
  - I request = i_pmem_read.
  - D request = d_pmem_read | d_pmem_write.
- IDLE with no request: stay in IDLE.
- IDLE with exactly one request: grant that requester.
- IDLE with both requesting: grant the requester that is not `last`.
- On a grant:
  - Enter BUSY_x.
  - Set `last` to x.
  - Latch the winner's command into the pmem_* output registers: pmem_address; pmem_read or pmem_write; pmem_wdata for D writes only.
- I grant: pmem_read=1, pmem_write=0. pmem_wdata holds its previous value.
- D grant with both d_pmem_read and d_pmem_write set: this input is illegal. The arbiter issues a write (pmem_write=1, pmem_read=0).
- BUSY_x:
  - Outputs are held constant regardless of requester inputs. A requester that drops its request mid-transaction does not abort it.
  - x_pmem_resp = pmem_resp, combinational. The other requester's resp is 0.
- On pmem_resp in BUSY_x, at the next edge:
  - Go to IDLE.
  - Clear pmem_read and pmem_write.
- i_pmem_rdata and d_pmem_rdata are both driven from pmem_rdata at all times. Only the selected resp qualifies them.
- pmem_resp in IDLE is ignored: no resp is forwarded and the state does not change.
- Reset (asynchronous, any state, mid-transaction included):
  - state=IDLE, `last`=D, so I wins the first tie.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - i_pmem_resp=0, d_pmem_resp=0.
- Requester rule: a cache deasserts its request in the cycle after it sees resp. A request still asserted in the IDLE cycle after resp is treated as a new transaction.

## Timing
- Request is sampled in IDLE at edge N. pmem_read or pmem_write is asserted from the cycle after N. Grant latency is 1 cycle.
- pmem_resp arrives in cycle M. x_pmem_resp is high in cycle M (0-cycle pass-through) and pmem_rdata is valid the same cycle.
- The pmem command deasserts in cycle M+1 (state IDLE).
- The next grant is taken at the edge ending M+1, and the next command is visible in M+2. This gives a minimum of one idle cycle between back-to-back transactions.
- With both requesters saturating, grants strictly alternate I, D, I, D.
- pmem_resp is assumed to be high for one cycle per transaction. A resp held longer than one cycle only affects the first cycle, because state is IDLE afterward.

## Test plan
- After reset, assert i_pmem_read=1, addr 0x1230 -> pmem_read=1, pmem_address=0x1230 in the next cycle. Memory returns resp after 3 cycles with rdata 0xA5..A5. Required: i_pmem_resp=1 that cycle with i_pmem_rdata=0xA5..A5, d_pmem_resp=0, pmem_read=0 in the following cycle.
- Simultaneous I read 0x0040 and D write 0x8000 with wdata 0x1111..11 right after reset -> I is granted first. D is granted next: pmem_write=1, pmem_address=0x8000, pmem_wdata=0x1111..11.
- Both requests held continuously for 6 transactions -> grant order I,D,I,D,I,D. No requester is granted twice in a row.
- D asserts read and write together with addr 0x2000 -> pmem_write=1 and pmem_read=0 are issued.
- Assert rst mid-BUSY_D, before pmem_resp -> pmem_read, pmem_write and both resps go to 0 immediately. After release, the I request is granted first.
- pmem_resp pulsed while IDLE -> no resp on either cache and no state change. D drops d_pmem_read mid-BUSY_D -> pmem_address and pmem_read hold until pmem_resp.
